// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
package bit_serializer_pkg;

    localparam int GAP_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a zero flag decoded from the registered count.
// Latency: load/decrement take effect on the next posedge; no backpressure.
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one accepted word leaves as WIDTH strobed bits, then GAP idle cycles.
// Latency: first bit one cycle after accept; in_ready stays low for the whole word and gap.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             en,
    output logic             d,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     BIT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             rdy_q;
    logic             rdy_d;
    logic             done_q;
    logic             done_d;

    logic accept;
    logic last_bit;
    logic bit_zero;
    logic gap_zero;

    assign accept   = in_valid && rdy_q;
    assign last_bit = (state_q == ST_SHIFT) && bit_zero;

    down_counter #(.W(CNT_W)) u_bit_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (BIT_LOAD),
        .dec_i      (state_q == ST_SHIFT),
        .zero_o     (bit_zero)
    );

    down_counter #(.W(GAP_CNT_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (last_bit),
        .load_val_i (GAP_LOAD),
        .dec_i      (state_q == ST_GAP),
        .zero_o     (gap_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_SHIFT;
            ST_SHIFT: if (bit_zero) state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_zero) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        en   = (state_q == ST_SHIFT);
        busy = (state_q != ST_IDLE);
        d    = 1'b0;
        if (state_q == ST_SHIFT) begin
            d = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
        end
        in_ready = rdy_q;
        done     = done_q;
    end

    // rdy is registered from the next state so it stays low through reset and rises one edge after release
    always_comb begin
        sr_d = sr_q;
        if (accept) begin
            sr_d = in_data;
        end else if (state_q == ST_SHIFT) begin
            sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
        end
        rdy_d  = (state_d == ST_IDLE);
        done_d = last_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            rdy_q  <= rdy_d;
            done_q <= done_d;
        end
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the single-bit capture flop. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per cycle on `d`, with `en` high exactly while a bit is valid. `en`/`d` connect directly to the enable and data inputs of the downstream capture register. Between words `en` is held low, so the downstream register holds its last value.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..64.
- `GAP`, 1: idle cycles inserted after each word with `en` low; legal range 0..15.
- `MSB_FIRST`, 0: 0 emits bit 0 first; 1 emits bit WIDTH-1 first.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WIDTH  upstream word; sampled only on accept.
- `in_ready`  out  1  block can accept a word this cycle.
- `en`  out  1  serial bit strobe to downstream.
- `d`  out  1  serial data bit; meaningful only when `en`=1.
- `busy`  out  1  high in SHIFT or GAP state.
- `done`  out  1  one-cycle pulse after the last bit of a word.

## Operation
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `in_ready`=1, `en`=0, `d`=0, `busy`=0.
  - An accept occurs when `in_valid`&&`in_ready` at a posedge. On accept: load the shift register with `in_data`, load the bit counter with WIDTH-1, go to SHIFT.
- SHIFT:
  - `en`=1.
  - `d` = shift register LSB (MSB when `MSB_FIRST`=1).
  - Shift by one each cycle and decrement the bit counter.
  - When the counter is 0 (last bit), the next state is GAP if GAP>0, else IDLE. `done` is registered high for the following cycle.
- GAP:
  - `en`=0, `d`=0.
  - The gap counter is loaded with GAP-1 on entry and decrements each cycle. Go to IDLE when it is 0.
- `in_valid` outside IDLE is ignored. `in_ready`=0 in SHIFT and GAP, so upstream must hold the word.
- Counter widths are $clog2(WIDTH) and 4 bits. No wrap-around is possible because both counters are reloaded before use.

## Timing
- Reset values while `rst_n`=0: `in_ready`=0, `en`=0, `d`=0, `busy`=0, `done`=0, state=IDLE, shift register=0.
- On `rst_n` deassertion: `in_ready` rises at the first posedge after release.
- Accept at edge k:
  - `en`=1 for cycles k+1 .. k+WIDTH.
  - `done`=1 in cycle k+WIDTH+1.
  - `in_ready`=1 again in cycle k+WIDTH+1+GAP.
- Back-to-back throughput: one word per WIDTH+GAP+1 cycles (the IDLE cycle is mandatory).
- Reset mid-word: outputs clear immediately (asynchronous). The partial word is discarded and no `done` is issued.
- `done` and `in_ready` coincide when GAP=0. An accept in that cycle is legal.

## Structure
- Package `bit_serializer_pkg`: state enum typedef (IDLE, SHIFT, GAP) and the `GAP_CNT_W`=4 constant.
- Sub-module `down_counter` (parameter width; ports: load, load value, decrement, zero flag). It is instantiated twice: once for bit count and once for gap count.

## Test plan
- Reset held 5 cycles with `in_valid`=1 -> `in_ready`/`en`/`d`/`done` all 0; `in_ready`=1 on the first edge after release.
- WIDTH=8, GAP=1, MSB_FIRST=0, accept 0xA5 -> `d` = 1,0,1,0,0,1,0,1 with `en`=1 for 8 cycles; `done` in the 9th cycle; `in_ready` back in the 10th.
- MSB_FIRST=1, accept 0x81 -> `d` = 1,0,0,0,0,0,0,1; downstream capture register ends at 1.
- GAP=0, `in_valid` held high with 0xFF then 0x00 -> exactly one `en`=0 cycle between words; the second word is accepted in the cycle `done`=1.
- `in_valid` pulsed with 0x3C during SHIFT of word 0x0F -> ignored; only 0x0F is serialized.
- `rst_n` low after the 3rd bit of 0xFF -> `en` drops immediately, no `done` pulse; the next accepted word 0x01 serializes correctly.
